// File: rtl/ahb_lite_sram_slave.sv
// AHB-lite SRAM responder with programmable wait states
// and a two-cycle ERROR response for illegal accesses.
module ahb_lite_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_WORDS   = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int AW = $clog2(MEM_WORDS) + 2;
  localparam int IW = AW - 2;

  localparam logic [2:0] WS_M1 =
    (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic [1:0]    state;
  logic [2:0]    cnt;
  logic          dp_act;
  logic          dp_wr;
  logic [IW-1:0] dp_idx;
  logic [3:0]    dp_be;
  logic [31:0]   mem [MEM_WORDS];

  logic       go;
  logic       ok_go;
  logic       in_win;
  logic       misalign;
  logic       bad_size;
  logic       illegal;
  logic [3:0] be;
  logic       commit;
  logic       unused_ok;

  assign unused_ok = ^{HBURST, HTRANS[0]};

  assign go     = HSEL & HREADY & HTRANS[1];
  assign in_win = HADDR[31:AW] == BASE_ADDR[31:AW];

  always_comb begin
    be       = 4'b0000;
    misalign = 1'b0;
    bad_size = 1'b0;
    unique case (HSIZE)
      2'b00: be = 4'b0001 << HADDR[1:0];
      2'b01: begin
        be       = HADDR[1] ? 4'b1100 : 4'b0011;
        misalign = HADDR[0];
      end
      2'b10: begin
        be       = 4'b1111;
        misalign = |HADDR[1:0];
      end
      default: bad_size = 1'b1;
    endcase
  end

  assign illegal = bad_size | misalign | ~in_win;
  assign ok_go   = go & ~illegal;

  // Error responses skip the wait counter entirely
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      unique case (state)
        S_IDLE, S_ERR2: begin
          if (go && illegal) begin
            state <= S_ERR1;
          end else if (ok_go && WAIT_STATES > 0) begin
            state <= S_WAIT;
            cnt   <= WS_M1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) state <= S_IDLE;
          else             cnt   <= cnt - 3'd1;
        end
        default: state <= S_ERR2;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_act <= 1'b0;
      dp_wr  <= 1'b0;
      dp_idx <= '0;
      dp_be  <= 4'b0000;
    end else if (HREADY) begin
      dp_act <= ok_go;
      dp_wr  <= HWRITE;
      dp_idx <= HADDR[AW-1:2];
      dp_be  <= be;
    end
  end

  assign HREADYOUT = (state == S_IDLE) | (state == S_ERR2);
  assign HRESP     = (state == S_ERR1) | (state == S_ERR2);
  assign commit    = dp_act & dp_wr & (state == S_IDLE);

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (dp_be[b]) mem[dp_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA = (dp_act && !dp_wr) ? mem[dp_idx] : 32'd0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: two instances (0 and 2 wait states)
// driven by a pipelined master against a byte-array reference model.
module tb_ahb_lite_sram_slave;

  localparam logic [31:0] BASE = 32'h0000_4000;
  localparam int MW = 64;
  localparam int WIN = MW * 4;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    bit          write;
    logic [1:0]  size;
    logic [31:0] wdata;
    bit          fixed;
    logic [31:0] fval;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        hsel [2];
  logic [31:0] haddr [2];
  logic        hwrite [2];
  logic [1:0]  hsize [2];
  logic [1:0]  htrans [2];
  logic [2:0]  hburst [2];
  logic [31:0] hwdata [2];
  logic        hreadyout [2];
  logic        hresp [2];
  logic [31:0] hrdata [2];

  int   n_chk = 0;
  int   n_err = 0;
  int   ws [2] = '{0, 2};
  logic [7:0] mb [2][WIN];
  cmd_t q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ahb_lite_sram_slave #(
      .BASE_ADDR(BASE),
      .MEM_WORDS(MW),
      .WAIT_STATES(g * 2)
    ) u_dut (
      .HCLK(clk),
      .HRESETn(rst_n[g]),
      .HSEL(hsel[g]),
      .HADDR(haddr[g]),
      .HWRITE(hwrite[g]),
      .HSIZE(hsize[g]),
      .HTRANS(htrans[g]),
      .HBURST(hburst[g]),
      .HWDATA(hwdata[g]),
      .HREADY(hreadyout[g]),
      .HREADYOUT(hreadyout[g]),
      .HRESP(hresp[g]),
      .HRDATA(hrdata[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit illegal(cmd_t c);
    return c.size == 2'b11
        || (c.size == 2'b01 && c.addr[0])
        || (c.size == 2'b10 && c.addr[1:0] != 2'b00)
        || c.addr < BASE
        || c.addr >= BASE + WIN;
  endfunction

  function automatic logic [31:0] mrd(int d, logic [31:0] a);
    int w;
    w = int'((a - BASE) >> 2) * 4;
    return {mb[d][w+3], mb[d][w+2], mb[d][w+1], mb[d][w]};
  endfunction

  task automatic mwr(int d, cmd_t c);
    int off;
    int n;
    off = int'(c.addr - BASE);
    n = 1 << c.size;
    for (int i = 0; i < n; i++)
      mb[d][off+i] = c.wdata[8*((off+i)%4) +: 8];
  endtask

  function automatic cmd_t mk(bit sel, logic [1:0] tr, logic [31:0] a,
                              bit wr, logic [1:0] sz, logic [31:0] wd);
    cmd_t c;
    c.sel = sel; c.trans = tr; c.addr = a; c.write = wr;
    c.size = sz; c.wdata = wd; c.fixed = 1'b0; c.fval = 32'd0;
    return c;
  endfunction

  function automatic cmd_t rd_fix(logic [31:0] a, logic [1:0] tr,
                                  logic [31:0] v);
    cmd_t c;
    c = mk(1, tr, a, 0, 2'b10, 32'd0);
    c.fixed = 1'b1;
    c.fval = v;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    int r;
    c.sel = ($urandom % 8) != 0;
    r = int'($urandom % 10);
    c.trans = r == 0 ? 2'b00 : r == 1 ? 2'b01 : r < 6 ? 2'b10 : 2'b11;
    r = int'($urandom % 20);
    if (r == 0)      c.addr = BASE - 32'($urandom_range(8, 1));
    else if (r == 1) c.addr = BASE + WIN + 32'($urandom_range(7, 0));
    else             c.addr = BASE + 32'($urandom % WIN);
    r = int'($urandom % 16);
    c.size = r == 0 ? 2'b11 : 2'(r % 3);
    if (($urandom % 4) != 0) begin
      if (c.size == 2'b01) c.addr[0] = 1'b0;
      if (c.size == 2'b10) c.addr[1:0] = 2'b00;
    end
    c.write = $urandom % 2 == 1;
    c.wdata = $urandom;
    c.fixed = 1'b0;
    c.fval = 32'd0;
    return c;
  endfunction

  task automatic run(input int d);
    cmd_t ac, dc;
    bit av, dv, prev, act, bad, rd;
    int waits, cyc, ew;
    av = 0; dv = 0; prev = 1; waits = 0; cyc = 0;
    while (q.size() > 0 || av || dv) begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        check("timeout", 32'(cyc), 32'd0);
        break;
      end
      if (prev) begin
        dc = ac; dv = av; waits = 0;
        if (q.size() > 0) begin ac = q.pop_front(); av = 1; end
        else av = 0;
        hsel[d]   = av && ac.sel;
        htrans[d] = av ? ac.trans : 2'b00;
        haddr[d]  = ac.addr;
        hwrite[d] = ac.write;
        hsize[d]  = ac.size;
        hburst[d] = 3'($urandom_range(7, 0));
        hwdata[d] = dv ? dc.wdata : $urandom;
      end
      if (dv) begin
        act = dc.sel && dc.trans[1];
        bad = act && illegal(dc);
        rd  = act && !bad && !dc.write;
        check("resp", 32'(hresp[d]), 32'(bad));
        if (hreadyout[d]) begin
          ew = !act ? 0 : bad ? 1 : ws[d];
          check("waits", 32'(waits), 32'(ew));
          if (rd) begin
            check("rdata", hrdata[d], mrd(d, dc.addr));
            if (dc.fixed) check("rdata_fix", hrdata[d], dc.fval);
          end else begin
            check("rdata_zero", hrdata[d], 32'd0);
            if (act && !bad) mwr(d, dc);
          end
        end else begin
          waits++;
        end
      end
      prev = hreadyout[d];
    end
    hsel[d] = 1'b0;
    htrans[d] = 2'b00;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; hsel[d] = 1'b0; haddr[d] = BASE;
      hwrite[d] = 1'b0; hsize[d] = 2'b10; htrans[d] = 2'b00;
      hburst[d] = 3'b000; hwdata[d] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(hreadyout[d]), 32'd1);
      check("rst_resp", 32'(hresp[d]), 32'd0);
      check("rst_rdata", hrdata[d], 32'd0);
      rst_n[d] = 1'b1;
    end
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < MW; w++)
        q.push_back(mk(1, 2'b10, BASE + 32'(w * 4), 1, 2'b10, $urandom));
      run(d);
    end

    q.push_back(mk(1, 2'b10, BASE + 32'h10, 1, 2'b10, 32'hDEAD_BEEF));
    q.push_back(rd_fix(BASE + 32'h10, 2'b10, 32'hDEAD_BEEF));
    q.push_back(mk(1, 2'b10, BASE + 32'h10, 1, 2'b10, 32'h1122_3344));
    q.push_back(mk(1, 2'b10, BASE + 32'h13, 1, 2'b00, {4{8'hAA}}));
    q.push_back(rd_fix(BASE + 32'h10, 2'b10, 32'hAA22_3344));
    q.push_back(mk(1, 2'b10, BASE + 32'h12, 1, 2'b01, {2{16'h5566}}));
    q.push_back(rd_fix(BASE + 32'h10, 2'b10, 32'h5566_3344));
    q.push_back(mk(1, 2'b10, BASE + 32'h12, 1, 2'b10, 32'h0BAD_0BAD));
    q.push_back(mk(1, 2'b10, BASE + 32'h10, 1, 2'b11, 32'h0BAD_0BAD));
    q.push_back(mk(1, 2'b10, BASE + WIN, 1, 2'b10, 32'h0BAD_0BAD));
    q.push_back(rd_fix(BASE + 32'h10, 2'b10, 32'h5566_3344));
    run(0);

    for (int i = 0; i < 4; i++)
      q.push_back(mk(1, 2'b10, BASE + 32'(i * 4), 1, 2'b10,
                     32'hA0B0_C000 + 32'(i)));
    for (int i = 0; i < 4; i++)
      q.push_back(rd_fix(BASE + 32'(i * 4), i == 0 ? 2'b10 : 2'b11,
                         32'hA0B0_C000 + 32'(i)));
    q.push_back(mk(1, 2'b10, BASE + 32'h2, 1, 2'b10, 32'h0BAD_0BAD));
    q.push_back(mk(1, 2'b10, BASE + 32'h4, 1, 2'b11, 32'h0BAD_0BAD));
    q.push_back(mk(1, 2'b10, BASE + WIN, 0, 2'b10, 32'd0));
    q.push_back(mk(1, 2'b10, BASE + 32'h8, 1, 2'b10, 32'h1111_2222));
    q.push_back(mk(1, 2'b01, BASE + 32'hC, 1, 2'b10, 32'h0BAD_0BAD));
    q.push_back(mk(1, 2'b11, BASE + 32'hC, 1, 2'b10, 32'h3333_4444));
    q.push_back(mk(0, 2'b10, BASE + 32'h0, 1, 2'b10, 32'h0BAD_0BAD));
    q.push_back(mk(1, 2'b00, BASE + 32'h4, 1, 2'b10, 32'h0BAD_0BAD));
    for (int i = 0; i < 4; i++)
      q.push_back(mk(1, 2'b10, BASE + 32'(i * 4), 0, 2'b10, 32'd0));
    run(1);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 250; i++) q.push_back(rnd_cmd());
      run(d);
    end

    @(negedge clk);
    hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1;
    hsize[1] = 2'b10; haddr[1] = BASE + 32'h20;
    @(negedge clk);
    hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'hCAFE_F00D;
    check("pre_rst_ready", 32'(hreadyout[1]), 32'd0);
    #2 rst_n[1] = 1'b0;
    #1;
    check("mid_rst_ready", 32'(hreadyout[1]), 32'd1);
    check("mid_rst_resp", 32'(hresp[1]), 32'd0);
    check("mid_rst_rdata", hrdata[1], 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    q.push_back(rd_fix(BASE + 32'h20, 2'b10, mrd(1, BASE + 32'h20)));
    run(1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
